// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and sizing helpers for the PLL reset sequencer
package pll_seq_pkg;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        QUALIFY   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_e;

    // One shared counter serves all three timed states, so it is sized for the longest
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL control/status bundle between sequencer and PLL/system side
interface pll_reset_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    import pll_seq_pkg::*;

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic                  pll_locked;
    logic                  clear_fault;
    logic                  pll_rst;
    logic                  sys_rst_n;
    logic                  ready;
    logic                  fault;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOSS_CNT_W-1:0] loss_count;

    modport master (
        input  pll_locked, clear_fault,
        output pll_rst, sys_rst_n, ready, fault, retry_cnt, loss_count
    );

    modport slave (
        output pll_locked, clear_fault,
        input  pll_rst, sys_rst_n, ready, fault, retry_cnt, loss_count
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer, synchronous active-low reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock-qualify sequencer; PLL_SEQ_LOSS_COUNT_EN builds the lock-loss counter
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);

    localparam logic [2:0] S_PLL_RST   = PLL_RST;
    localparam logic [2:0] S_WAIT_LOCK = WAIT_LOCK;
    localparam logic [2:0] S_QUALIFY   = QUALIFY;
    localparam logic [2:0] S_RUN       = RUN;
    localparam logic [2:0] S_FAULT     = FAULT;

    localparam logic [CNT_W-1:0]   RST_TC    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_TC     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic               lock_s;
    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_nxt;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lock_s)
    );

    // A live lock in WAIT_LOCK beats a coincident timeout
    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        case (state)
            S_PLL_RST: begin
                if (cnt == RST_TC) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = S_QUALIFY;
                end else if (cnt == TO_TC) begin
                    if (retry == RETRY_MAX) begin
                        state_nxt = S_FAULT;
                    end else begin
                        state_nxt = S_PLL_RST;
                        retry_nxt = retry + RETRY_W'(1);
                    end
                end
            end
            S_QUALIFY: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == STABLE_TC) begin
                    state_nxt = S_RUN;
                    retry_nxt = '0;
                end
            end
            S_RUN: begin
                if (!lock_s) state_nxt = S_PLL_RST;
            end
            S_FAULT: begin
                if (bus.clear_fault) begin
                    state_nxt = S_PLL_RST;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = S_PLL_RST;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state <= S_PLL_RST;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_nxt;
            retry <= retry_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state == S_PLL_RST || state == S_WAIT_LOCK || state == S_QUALIFY)
                cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    always_ff @(posedge refclk) begin
        if (!rst_n)
            loss_q <= '0;
        else if (state == S_RUN && !lock_s && loss_q != '1)
            loss_q <= loss_q + LOSS_CNT_W'(1);
    end

    assign bus.loss_count = loss_q;
`else
    assign bus.loss_count = '0;
`endif

    assign bus.pll_rst   = (state == S_PLL_RST) || (state == S_FAULT);
    assign bus.sys_rst_n = (state == S_RUN);
    assign bus.ready     = (state == S_RUN);
    assign bus.fault     = (state == S_FAULT);
    assign bus.retry_cnt = retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    typedef struct {
        bit          rst_n;
        bit          locked;
        bit          clr;
        int          n;
        logic [13:0] exp;
    } vec_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [13:0] exp;
    } sb_t;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    sb_t  sb[$];

    pll_reset_sequencer_if #(.MAX_RETRIES(2)) bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT       (32),
        .LOCK_STABLE_CYCLES (16),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [7:0] lc(int n);
        if (!LOSS_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    function automatic vec_t mk(bit r, bit lk, bit c, int n, bit prst, bit sys, bit rdy,
                                bit flt, int rty, logic [7:0] loss);
        vec_t v;
        v.rst_n  = r;
        v.locked = lk;
        v.clr    = c;
        v.n      = n;
        v.exp    = {prst, sys, rdy, flt, 2'(rty), loss};
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fault, bus.retry_cnt, bus.loss_count};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expectations carry the cycle at which the DUT must show them
    always @(negedge refclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            check($sformatf("vec%0d {prst,sys,rdy,flt,retry,loss}", e.idx), 32'(outs()), 32'(e.exp));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.pll_locked  = 1'b0;
        bus.clear_fault = 1'b0;

        //                rst lk clr  n  prst sys rdy flt rty loss
        vecs.push_back(mk(0, 0, 0,  3, 1, 0, 0, 0, 0, lc(0)));  // reset values
        vecs.push_back(mk(1, 0, 0,  3, 1, 0, 0, 0, 0, lc(0)));
        vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0, lc(0)));  // pll_rst high exactly 4
        vecs.push_back(mk(1, 0, 0,  6, 0, 0, 0, 0, 0, lc(0)));
        vecs.push_back(mk(1, 1, 0, 18, 0, 0, 0, 0, 0, lc(0)));  // not yet released
        vecs.push_back(mk(1, 1, 0,  1, 0, 1, 1, 0, 0, lc(0)));  // released 19 after lock
        vecs.push_back(mk(1, 0, 0,  2, 0, 1, 1, 0, 0, lc(0)));  // lock loss, still RUN
        vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 0, lc(1)));  // 3 cycles after loss
        vecs.push_back(mk(1, 0, 0,  3, 1, 0, 0, 0, 0, lc(1)));
        vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0, lc(1)));
        vecs.push_back(mk(1, 1, 0,  8, 0, 0, 0, 0, 0, lc(1)));  // short lock pulse
        vecs.push_back(mk(1, 0, 0,  3, 0, 0, 0, 0, 0, lc(1)));  // back in WAIT_LOCK
        vecs.push_back(mk(1, 0, 0, 31, 0, 0, 0, 0, 0, lc(1)));  // fresh timeout
        vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 1, lc(1)));
        vecs.push_back(mk(1, 0, 0,  3, 1, 0, 0, 0, 1, lc(1)));
        vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 1, lc(1)));
        vecs.push_back(mk(1, 0, 0, 31, 0, 0, 0, 0, 1, lc(1)));
        vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 0, 2, lc(1)));  // 36-cycle retry period
        vecs.push_back(mk(1, 0, 0,  4, 0, 0, 0, 0, 2, lc(1)));
        vecs.push_back(mk(1, 0, 0, 31, 0, 0, 0, 0, 2, lc(1)));
        vecs.push_back(mk(1, 0, 0,  1, 1, 0, 0, 1, 2, lc(1)));  // FAULT on third timeout
        vecs.push_back(mk(1, 0, 0, 50, 1, 0, 0, 1, 2, lc(1)));  // held in FAULT
        vecs.push_back(mk(1, 0, 1,  1, 1, 0, 0, 0, 0, lc(1)));  // clear_fault
        vecs.push_back(mk(1, 0, 0,  3, 1, 0, 0, 0, 0, lc(1)));
        vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0, lc(1)));
        vecs.push_back(mk(1, 0, 1,  1, 0, 0, 0, 0, 0, lc(1)));  // clear ignored in WAIT_LOCK
        vecs.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0, lc(1)));
        vecs.push_back(mk(1, 1, 0,  5, 0, 0, 0, 0, 0, lc(1)));  // into QUALIFY
        vecs.push_back(mk(0, 1, 0,  1, 1, 0, 0, 0, 0, lc(0)));  // reset mid-QUALIFY
        vecs.push_back(mk(1, 0, 0,  4, 0, 0, 0, 0, 0, lc(0)));
        vecs.push_back(mk(1, 0, 0, 32, 1, 0, 0, 0, 1, lc(0)));
        vecs.push_back(mk(1, 0, 0, 36, 1, 0, 0, 0, 2, lc(0)));
        vecs.push_back(mk(1, 0, 0, 36, 1, 0, 0, 1, 2, lc(0)));  // FAULT again
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 0, lc(0)));  // reset mid-FAULT
        vecs.push_back(mk(1, 0, 0,  4, 0, 0, 0, 0, 0, lc(0)));

        @(negedge refclk);
        for (int i = 0; i < vecs.size(); i++) begin
            sb_t e;
            rst_n           = vecs[i].rst_n;
            bus.pll_locked  = vecs[i].locked;
            bus.clear_fault = vecs[i].clr;
            e.cyc = cyc + vecs[i].n;
            e.idx = i;
            e.exp = vecs[i].exp;
            sb.push_back(e);
            repeat (vecs[i].n) @(negedge refclk);
        end
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // 300 acquire/loss cycles to push the loss counter past saturation
        for (int i = 0; i < 300; i++) begin
            bus.pll_locked = 1'b1;
            repeat (19) @(negedge refclk);
            if (i < 3 || i == 299) check($sformatf("loop%0d_ready", i), 32'(bus.ready), 32'd1);
            bus.pll_locked = 1'b0;
            repeat (3) @(negedge refclk);
            if (i < 3 || i == 299)
                check($sformatf("loop%0d_prst_sys", i), 32'({bus.pll_rst, bus.sys_rst_n}), 32'b10);
            if (i == 0 || i == 253 || i == 254 || i == 255 || i == 299)
                check($sformatf("loop%0d_loss_count", i), 32'(bus.loss_count), 32'(lc(i + 1)));
            repeat (4) @(negedge refclk);
        end
        check("final_retry_cnt", 32'(bus.retry_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences reset and lock qualification for the 50 MHz → 200 MHz PLL. Sits beside the PLL in the free-running reference-clock domain: drives the PLL's `rst`, consumes its asynchronous `locked`, qualifies lock stability, and releases the system reset only after a stable lock. Retries PLL reset on lock timeout, reports a fault after repeated failures, and re-sequences on lock loss.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥2).
- `LOCK_TIMEOUT`, 65536: cycles in WAIT_LOCK before a retry (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥2).
- `MAX_RETRIES`, 3: retries allowed before FAULT (≥1).
- `refclk`  in  1  free-running 50 MHz reference clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `pll_locked`  in  1  PLL lock indication, asynchronous to `refclk`.
- `clear_fault`  in  1  single-cycle request to leave FAULT.
- `pll_rst`  out  1  active-high PLL reset.
- `sys_rst_n`  out  1  active-low system reset, refclk domain; 200 MHz consumers resynchronize it.
- `ready`  out  1  high only in RUN.
- `fault`  out  1  high only in FAULT.
- `retry_cnt`  out  $clog2(MAX_RETRIES+1)  retries consumed since the last successful lock.
- `loss_count`  out  8  saturating lock-loss event count.

## Operation
- `pll_locked` is passed through a 2-flop synchronizer to give `lock_s`; synchronizer flops reset to 0.
- There is one shared cycle counter `cnt`, cleared on every state change.
- States and transitions:
  - PLL_RST: `pll_rst`=1. Goes to WAIT_LOCK when `cnt`==PLL_RST_CYCLES-1.
  - WAIT_LOCK: `pll_rst`=0.
    - `lock_s`=1 → QUALIFY.
    - Otherwise at `cnt`==LOCK_TIMEOUT-1: if `retry_cnt`==MAX_RETRIES → FAULT; else `retry_cnt`+1 and → PLL_RST.
  - QUALIFY: `lock_s`=0 → WAIT_LOCK, with a fresh timeout and no retry consumed. At `cnt`==LOCK_STABLE_CYCLES-1 with `lock_s`=1 → RUN and clear `retry_cnt`.
  - RUN: `sys_rst_n`=1, `ready`=1. `lock_s`=0 → PLL_RST and `loss_count`+1; the count saturates at 255.
  - FAULT: `pll_rst`=1 held, `fault`=1. `clear_fault`=1 → PLL_RST and clear `retry_cnt`. `clear_fault` is ignored in all other states.
- `lock_s`=0 and the timeout terminal count in the same WAIT_LOCK cycle → the timeout wins. `lock_s`=1 in the same cycle → QUALIFY wins.
- All outputs are registered and decoded from the state register; there are no combinational paths from inputs.

## Timing
- Reset values (rst_n=0 at an edge): state PLL_RST, `cnt`=0, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0, `loss_count`=0.
- Reset mid-operation takes effect at the next edge, from any state.
- After `rst_n` rises, `pll_rst` stays high for exactly PLL_RST_CYCLES edges.
- Lock acquire latency: `pll_locked` rise (held) → `sys_rst_n` rise is exactly LOCK_STABLE_CYCLES+3 cycles.
- Lock loss latency: `pll_locked` fall → `sys_rst_n`=0 and `pll_rst`=1 is exactly 3 cycles.
- Retry period with no lock: LOCK_TIMEOUT + PLL_RST_CYCLES cycles.

## Configuration
- `PLL_SEQ_LOSS_COUNT_EN`
  - Defined: `loss_count` is implemented as above.
  - Undefined: `loss_count` is tied to 8'd0 and no counter flops are built.
- All other behaviour is identical in both builds.

## Structure
- Shared package `pll_seq_pkg`:
  - state enum typedef (PLL_RST, WAIT_LOCK, QUALIFY, RUN, FAULT);
  - `LOSS_CNT_W`=8;
  - a width helper for `cnt`: $clog2 of the maximum of the three cycle parameters.
- Sub-module `sync_2ff`: a single-bit, 2-flop synchronizer with synchronous active-low reset, reusable across the codebase.

## Test plan
Parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=16, MAX_RETRIES=2.
- Release `rst_n`; raise `pll_locked` 10 cycles later and hold → `pll_rst` high for 4 cycles; `sys_rst_n`=1 and `ready`=1 exactly 19 cycles after the lock rise; `retry_cnt`=0.
- In QUALIFY, pulse `pll_locked` high for 8 cycles then low → no RUN entry, `sys_rst_n` stays 0, state returns to WAIT_LOCK, `retry_cnt` unchanged.
- Hold `pll_locked`=0 → `pll_rst` pulses 4 cycles every 36; `retry_cnt` steps 1, 2; on the third timeout `fault`=1 and `pll_rst` is held 1. Then pulse `clear_fault` → `fault`=0, `retry_cnt`=0, a 4-cycle PLL_RST follows.
- In RUN, drop `pll_locked` → 3 cycles later `sys_rst_n`=0 and `pll_rst`=1 for 4 cycles; `loss_count`=1. After 300 loss events `loss_count`=255.
- Assert `rst_n`=0 mid-QUALIFY and mid-FAULT → all outputs take their reset values at the next edge.
- Build without `PLL_SEQ_LOSS_COUNT_EN`, repeat the lock-loss scenario → `loss_count` stays 0 and all other responses are unchanged.
